// File: rtl/microwave_pkg.sv
// microwave_pkg: shared key indices and debounce defaults for the microwave front panel
package microwave_pkg;
    localparam int KEY_START       = 0;
    localparam int KEY_STOP        = 1;
    localparam int KEY_DOOR        = 2;
    localparam int KEY_PLUS        = 3;
    localparam int DEBOUNCE_STABLE = 4;
    localparam int DEBOUNCE_HOLD   = 16;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one key channel with synchroniser, stability counter, edge pulses and long-press flag
module debounce_channel
    import microwave_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = DEBOUNCE_STABLE,
    parameter int   HOLD_CYCLES   = DEBOUNCE_HOLD,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic sample_en,
    input  logic key_in,
    output logic key_level,
    output logic key_rise,
    output logic key_fall,
    output logic key_held
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic s, change, level_d;
    assign s = sync_q[SYNC_STAGES-1];
    // hold_cnt follows the next level so held drops on the very edge the level falls
    always_comb begin
        change  = sample_en && (s != key_level) && (cnt_q == CNT_LAST);
        cnt_d   = !sample_en ? cnt_q : (s == key_level || change) ? '0 : cnt_q + 1'b1;
        level_d = change ? s : key_level;
        hold_d  = (!level_d || (change && s)) ? '0 :
                  (sample_en && hold_q != HOLD_MAX) ? hold_q + 1'b1 : hold_q;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= {SYNC_STAGES{RESET_LEVEL}};
            key_level <= RESET_LEVEL;
            cnt_q     <= '0;
            hold_q    <= '0;
            key_rise  <= 1'b0;
            key_fall  <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], key_in};
            key_level <= level_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            key_rise  <= change && s;
            key_fall  <= change && !s;
            key_held  <= (hold_d == HOLD_MAX);
        end
    end
endmodule

// File: rtl/keypad_debouncer.sv
// keypad_debouncer: CHANNELS independent debounce channels sharing clock, reset and sample tick
module keypad_debouncer
    import microwave_pkg::*;
#(
    parameter int   CHANNELS      = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = DEBOUNCE_STABLE,
    parameter int   HOLD_CYCLES   = DEBOUNCE_HOLD,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] key_in,
    output logic [CHANNELS-1:0] key_level,
    output logic [CHANNELS-1:0] key_rise,
    output logic [CHANNELS-1:0] key_fall,
    output logic [CHANNELS-1:0] key_held
);
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .RESET_LEVEL  (RESET_LEVEL)
        ) u_ch (
            .clk      (clk),
            .resetn   (resetn),
            .sample_en(sample_en),
            .key_in   (key_in[g]),
            .key_level(key_level[g]),
            .key_rise (key_rise[g]),
            .key_fall (key_fall[g]),
            .key_held (key_held[g])
        );
    end
endmodule

// File: tb/tb_keypad_debouncer.sv
// tb_keypad_debouncer: scoreboard bench with a run-length reference model plus directed timing checks
module tb_keypad_debouncer;
    localparam int CH = 4, SS = 2, ST = 4, HD = 16;
    logic clk = 1'b0, resetn = 1'b0, sample_en = 1'b0;
    logic [CH-1:0] key_in = '0;
    logic [CH-1:0] key_level, key_rise, key_fall, key_held;
    int errors = 0, checks = 0;

    keypad_debouncer #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .STABLE_CYCLES(ST), .HOLD_CYCLES(HD), .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk), .resetn(resetn), .sample_en(sample_en), .key_in(key_in),
        .key_level(key_level), .key_rise(key_rise), .key_fall(key_fall), .key_held(key_held)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] lvl, rise, fall, held;
    } obs_t;
    obs_t exp_q[$];

    // reference model: input history, mismatch run length, age of the current high level
    logic [CH-1:0] hist[$];
    int run[CH], age[CH];
    logic [CH-1:0] m_lvl;

    task automatic model_edge();
        obs_t o;
        logic [CH-1:0] s;
        o = '0;
        if (!resetn) begin
            hist = {};
            repeat (SS) hist.push_front('0);
            for (int c = 0; c < CH; c++) begin run[c] = 0; age[c] = 0; end
            m_lvl = '0;
        end else begin
            s = hist[SS-1];
            hist.push_front(key_in);
            void'(hist.pop_back());
            for (int c = 0; c < CH; c++) begin
                if (sample_en) begin
                    if (s[c] == m_lvl[c]) begin
                        run[c] = 0;
                        age[c] = m_lvl[c] ? ((age[c] + 1 > HD) ? HD : age[c] + 1) : 0;
                    end else begin
                        run[c] = run[c] + 1;
                        if (run[c] == ST) begin
                            m_lvl[c] = s[c];
                            run[c] = 0;
                            age[c] = 0;
                            o.rise[c] = s[c];
                            o.fall[c] = !s[c];
                        end else begin
                            age[c] = m_lvl[c] ? ((age[c] + 1 > HD) ? HD : age[c] + 1) : 0;
                        end
                    end
                end
                o.held[c] = m_lvl[c] && (age[c] >= HD);
            end
            o.lvl = m_lvl;
        end
        exp_q.push_back(o);
    endtask

    task automatic step(input logic [CH-1:0] k, input logic en);
        key_in = k;
        sample_en = en;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every clock the DUT presents a full output vector; compare with the queued prediction
    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({key_level, key_rise, key_fall, key_held} !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got lvl=%b rise=%b fall=%b held=%b expected lvl=%b rise=%b fall=%b held=%b",
                         $time, key_level, key_rise, key_fall, key_held, e.lvl, e.rise, e.fall, e.held);
            end
        end
    end

    initial begin
        logic [CH-1:0] k;
        int rises;
        k = '0;
        repeat (3) step(k, 1'b1);
        check("reset_outputs", {key_level, key_rise, key_fall, key_held}, '0);
        resetn = 1'b1;
        // build up cnt = 2 on channel 0, then reset asynchronously
        k[0] = 1'b1;
        repeat (4) step(k, 1'b1);
        check("midcount_no_level", key_level[0], 1'b0);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1 check("async_reset_outputs", {key_level, key_rise, key_fall, key_held}, '0);
        repeat (2) step(k, 1'b1);
        resetn = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            step(k, 1'b1);
            if (i < 5) check("post_reset_quiet", {key_level[0], key_rise[0]}, 2'b00);
            if (i == 5) check("post_reset_rise_edge5", {key_level[0], key_rise[0]}, 2'b11);
            if (i == 6) check("post_reset_rise_once", {key_level[0], key_rise[0]}, 2'b10);
        end
        // glitch on channel 1: three clocks high is one short of the stability window
        k[1] = 1'b1;
        repeat (3) step(k, 1'b1);
        k[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(k, 1'b1);
            check("glitch_no_change", {key_level[1], key_rise[1], key_fall[1]}, 3'b000);
        end
        // bounce on channel 2
        for (int i = 0; i < 5; i++) begin
            k[2] = (i % 2 == 0);
            step(k, 1'b1);
        end
        rises = 0;
        for (int i = 1; i <= 8; i++) begin
            step(k, 1'b1);
            rises += key_rise[2];
            if (i == 4) check("bounce_not_yet", key_level[2], 1'b0);
            if (i == 5) check("bounce_rise_edge5", key_rise[2], 1'b1);
        end
        check("bounce_single_rise", rises, 1);
        // sample enable every 4th clock on channel 3
        k[3] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(k, (i % 4) == 3);
            if (i == 14) check("sen_before", key_level[3], 1'b0);
            if (i == 15) check("sen_rise", {key_level[3], key_rise[3]}, 2'b11);
            if (i == 16) check("sen_pulse_one_clock", key_rise[3], 1'b0);
        end
        // held on channel 0: drop it first, then a fresh long press
        k[0] = 1'b0;
        repeat (10) step(k, 1'b1);
        k[0] = 1'b1;
        for (int i = 0; i < 35; i++) begin
            step(k, 1'b1);
            if (i == 5) check("held_press_rise", key_rise[0], 1'b1);
            if (i == 20) check("held_not_yet", key_held[0], 1'b0);
            if (i == 21) check("held_asserts", key_held[0], 1'b1);
        end
        k[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(k, 1'b1);
            if (i == 4) check("held_before_fall", {key_level[0], key_held[0]}, 2'b11);
            if (i == 5) check("fall_with_held_drop", {key_level[0], key_fall[0], key_held[0]}, 3'b010);
        end
        // parallel rise on all channels
        k = '0;
        repeat (10) step(k, 1'b1);
        k = '1;
        for (int i = 0; i < 9; i++) begin
            step(k, 1'b1);
            check("parallel_rise", key_rise, (i == 5) ? {CH{1'b1}} : {CH{1'b0}});
        end
        // randomized bouncing keys with an irregular sample tick
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(9) == 0) k[c] = ~k[c];
            step(k, $urandom_range(3) != 0);
        end
        // long steady stretch so held and falls are exercised from random state
        k = 4'b0101;
        repeat (40) step(k, 1'b1);
        k = 4'b1010;
        repeat (40) step(k, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
